// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for avalon_multi_timer.
//
// Signals:
//   address     word address; upper bits select the channel, [1:0] the register
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    32-bit registered read data (driven by the slave)
//
// Modports:
//   master  bus master (CPU side or testbench)
//   slave   the timer block
interface avalon_multi_timer_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/avalon_multi_timer.sv
// NUM_CH independent down-counting interval timers behind one Avalon-MM
// slave. Each channel has an 8-bit prescaler, one-shot/continuous mode, a
// snapshot register and a level interrupt.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous, active-low reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   irq      per-channel interrupt, TO & ITO
//   irq_any  OR of all irq bits
//
// Per-channel register map (address[1:0]):
//   0 STATUS   bit0 TO (write 1 to clear), bit1 RUN (read-only)
//   1 CONTROL  bit0 ITO, bit1 CONT, bit2 START, bit3 STOP, bits[15:8] PRESC
//   2 PERIOD   CNT_W bits; a write reloads the counter and stops the channel
//   3 SNAP     a write captures the counter; a read returns the capture
module avalon_multi_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 49999
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_multi_timer_if.slave bus,
    output logic [NUM_CH-1:0]   irq,
    output logic                irq_any
);

    localparam int ADDR_W = $clog2(NUM_CH) + 2;
    // With a single channel there is no channel field; keep a 1-bit index.
    localparam int CH_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SNAP    = 2'd3;

    logic [CH_W-1:0]        ch_idx;
    logic [1:0]             reg_idx;
    logic                   ch_valid;
    logic                   wr_en;
    logic [NUM_CH-1:0][31:0] rd_ch;
    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    if (ADDR_W > 2) begin : g_ch_field
        assign ch_idx = bus.address[ADDR_W-1:2];
    end else begin : g_no_ch_field
        assign ch_idx = '0;
    end

    assign reg_idx  = bus.address[1:0];
    // Channel indices that decode to a non-existent channel read 0 and
    // ignore writes.
    assign ch_valid = (32'(ch_idx) < 32'(NUM_CH));
    assign wr_en    = bus.chipselect & ~bus.write_n & ch_valid;

    // Not every writedata bit lands in a register for every CNT_W.
    assign unused_wdata = ^bus.writedata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] period_q;
        logic [CNT_W-1:0] counter_q;
        logic [CNT_W-1:0] snap_q;
        logic [7:0]       presc_q;
        logic [7:0]       pcount_q;
        logic             ito_q;
        logic             cont_q;
        logic             run_q;
        logic             to_q;

        logic             sel;
        logic             wr_status;
        logic             wr_control;
        logic             wr_period;
        logic             wr_snap;
        logic             tick;
        logic             timeout;

        assign sel        = wr_en && (ch_idx == CH_W'(i));
        assign wr_status  = sel && (reg_idx == REG_STATUS);
        assign wr_control = sel && (reg_idx == REG_CONTROL);
        assign wr_period  = sel && (reg_idx == REG_PERIOD);
        assign wr_snap    = sel && (reg_idx == REG_SNAP);

        assign tick    = run_q && (pcount_q == presc_q);
        // A period write on a tick cycle suppresses the timeout entirely.
        assign timeout = tick && (counter_q == '0) && !wr_period;

        // Later assignments in this block take priority: tick handling first,
        // then bus writes, with the PERIOD load overriding everything else.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                period_q  <= RST_PERIOD;
                counter_q <= RST_PERIOD;
                snap_q    <= '0;
                presc_q   <= '0;
                pcount_q  <= '0;
                ito_q     <= 1'b0;
                cont_q    <= 1'b0;
                run_q     <= 1'b0;
                to_q      <= 1'b0;
            end else begin
                if (run_q) begin
                    pcount_q <= tick ? 8'd0 : pcount_q + 8'd1;
                end

                if (tick && (counter_q != '0)) begin
                    counter_q <= counter_q - CNT_W'(1);
                end

                if (timeout) begin
                    counter_q <= period_q;
                    to_q      <= 1'b1;
                    if (!cont_q) begin
                        run_q <= 1'b0;
                    end
                end

                // A clear colliding with a fresh timeout loses, so the event
                // is never dropped.
                if (wr_status && bus.writedata[0] && !timeout) begin
                    to_q <= 1'b0;
                end

                if (wr_control) begin
                    ito_q   <= bus.writedata[0];
                    cont_q  <= bus.writedata[1];
                    presc_q <= bus.writedata[15:8];
                    if (bus.writedata[3]) begin
                        run_q <= 1'b0;
                    end else if (bus.writedata[2]) begin
                        run_q <= 1'b1;
                    end
                end

                // Sampled before this cycle's decrement.
                if (wr_snap) begin
                    snap_q <= counter_q;
                end

                if (wr_period) begin
                    period_q  <= bus.writedata[CNT_W-1:0];
                    counter_q <= bus.writedata[CNT_W-1:0];
                    pcount_q  <= '0;
                    run_q     <= 1'b0;
                end
            end
        end

        assign irq[i] = to_q & ito_q;

        assign rd_ch[i] =
            (reg_idx == REG_STATUS)  ? {30'd0, run_q, to_q} :
            (reg_idx == REG_CONTROL) ? {16'd0, presc_q, 6'd0, cont_q, ito_q} :
            (reg_idx == REG_PERIOD)  ? 32'(period_q) :
                                       32'(snap_q);
    end

    assign irq_any = |irq;

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_valid && (ch_idx == CH_W'(c))) begin
                rd_mux = rd_ch[c];
            end
        end
    end

    // Read data is re-registered every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

endmodule
